// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter in front of a shared combinational ALU.
// Each granted operation takes one ISSUE cycle, then its result is held in RESP until the owner accepts it.
module alu_share_arbiter #(
  parameter int WIDTH   = 64,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH:0]   alu_result,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH:0]   rsp_result,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic             ill_q, ill_d;
  logic [WIDTH:0]   res_q, res_d;
  logic             err_q, err_d;
  logic             grant0, grant1;
  logic             owner_rdy;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Grants exist only in IDLE; on contention the priority pointer decides.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid && (!req1_valid || !prio_q)) begin
        grant0 = 1'b1;
      end else if (req1_valid && (!req0_valid || prio_q)) begin
        grant1 = 1'b1;
      end
    end
  end

  assign owner_rdy = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    ill_d   = ill_q;
    res_d   = res_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          a_d     = req0_a;
          b_d     = req0_b;
          op_d    = op_legal(req0_op) ? req0_op : 4'b0000;
          ill_d   = !op_legal(req0_op);
          owner_d = 1'b0;
          prio_d  = 1'b1;
          state_d = ISSUE;
        end else if (grant1) begin
          a_d     = req1_a;
          b_d     = req1_b;
          op_d    = op_legal(req1_op) ? req1_op : 4'b0000;
          ill_d   = !op_legal(req1_op);
          owner_d = 1'b1;
          prio_d  = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // An illegal op still exercises the ALU as AND, but its result is discarded.
        res_d   = ill_q ? '0 : alu_result;
        err_d   = ill_q;
        state_d = RESP;
      end
      RESP: begin
        if (owner_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      prio_q  <= RR_INIT;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 4'b0000;
      ill_q   <= 1'b0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp0_valid = (state_q == RESP) && !owner_q;
  assign rsp1_valid = (state_q == RESP) && owner_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized and directed bench for alu_share_arbiter with a transaction-level arbitration model
// and a response scoreboard.
module tb_alu_share_arbiter;
  localparam int W       = 64;
  localparam bit RR_INIT = 1'b0;

  logic         clk = 1'b0;
  logic         reset;
  logic         rv   [2];
  logic [W-1:0] ra   [2];
  logic [W-1:0] rb   [2];
  logic [3:0]   rop  [2];
  logic         rr   [2];
  logic         req0_ready, req1_ready;
  logic [W-1:0] alu_a, alu_b;
  logic [3:0]   alu_op;
  logic [W:0]   alu_result;
  logic         rsp0_valid, rsp1_valid;
  logic [W:0]   rsp_result;
  logic         rsp_err, busy;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(W), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(rv[0]), .req0_ready(req0_ready), .req0_a(ra[0]), .req0_b(rb[0]), .req0_op(rop[0]),
    .req1_valid(rv[1]), .req1_ready(req1_ready), .req1_a(ra[1]), .req1_b(rb[1]), .req1_op(rop[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rr[0]), .rsp1_ready(rr[1]),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural 65-bit ALU: operands are zero-extended, results wrap modulo 2^65.
  function automatic logic [W:0] alu_fn(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] xa, xb;
    xa = {1'b0, a};
    xb = {1'b0, b};
    case (op)
      4'b0000: return xa & xb;
      4'b0001: return xa | xb;
      4'b0010: return xa + xb;
      4'b0110: return xa - xb;
      4'b1100: return ~(xa | xb);
      4'b1000: return xa << b;
      default: return '0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] op);
    return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000};
  endfunction

  assign alu_result = alu_fn(alu_op, alu_a, alu_b);

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } stim_t;

  typedef struct {
    bit         port;
    logic [W:0] res;
    bit         err;
  } exp_t;

  stim_t stq0[$];
  stim_t stq1[$];
  exp_t  sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Arbitration model: the unit is free or holds one transaction (issuing, then responding).
  int           m_phase = 0;
  bit           m_prio  = RR_INIT;
  bit           m_owner = 1'b0;
  logic [W-1:0] m_a, m_b;
  logic [3:0]   m_op;
  bit           acc0 = 1'b0, acc1 = 1'b0;

  always @(negedge clk) begin
    bit e0, e1;
    if (!reset) begin
      m_phase = 0;
      m_prio  = RR_INIT;
      acc0    = 1'b0;
      acc1    = 1'b0;
      sb.delete();
      chk("rst_alu_a", alu_a, '0);
      chk("rst_alu_b", alu_b, '0);
      chk("rst_alu_op", alu_op, '0);
      chk("rst_rsp_result", rsp_result, '0);
      chk("rst_rsp_err", rsp_err, '0);
      chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, '0);
      chk("rst_busy", busy, '0);
    end else begin
      e0 = (m_phase == 0) && rv[0] && (!rv[1] || !m_prio);
      e1 = (m_phase == 0) && rv[1] && (!rv[0] || m_prio);
      chk("req0_ready", req0_ready, e0);
      chk("req1_ready", req1_ready, e1);
      chk("busy", busy, m_phase != 0);
      chk("rsp0_valid", rsp0_valid, (m_phase == 2) && !m_owner);
      chk("rsp1_valid", rsp1_valid, (m_phase == 2) && m_owner);
      if (m_phase == 1) begin
        chk("issue_alu_a", alu_a, m_a);
        chk("issue_alu_b", alu_b, m_b);
        chk("issue_alu_op", alu_op, legal(m_op) ? m_op : 4'b0000);
      end
      acc0 = e0;
      acc1 = e1;
      case (m_phase)
        0: if (e0 || e1) begin
          m_owner = e1;
          m_a     = ra[e1];
          m_b     = rb[e1];
          m_op    = rop[e1];
          m_prio  = !e1;
          sb.push_back('{port: e1, res: legal(m_op) ? alu_fn(m_op, m_a, m_b) : '0, err: !legal(m_op)});
          m_phase = 1;
        end
        1: m_phase = 2;
        default: if (rr[m_owner]) m_phase = 0;
      endcase
    end
  end

  // Response monitor: whenever a response is presented it must match the oldest outstanding op.
  always @(negedge clk) begin
    exp_t e;
    if (reset && (rsp0_valid || rsp1_valid)) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sb[0];
        chk("rsp_port", rsp1_valid, e.port);
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_err", rsp_err, e.err);
        if ((rsp0_valid && rr[0]) || (rsp1_valid && rr[1])) void'(sb.pop_front());
      end
    end
  end

  // Request/response-ready drivers: a request stays valid until accepted, then the next is presented.
  bit rnd_rdy = 1'b0;
  bit rdy_force [2] = '{1'b1, 1'b1};

  initial begin
    stim_t s;
    rv  = '{1'b0, 1'b0};
    ra  = '{'0, '0};
    rb  = '{'0, '0};
    rop = '{4'b0, 4'b0};
    rr  = '{1'b1, 1'b1};
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        rv[0] = 1'b0;
        rv[1] = 1'b0;
      end else begin
        if (acc0) rv[0] = 1'b0;
        if (acc1) rv[1] = 1'b0;
        if (!rv[0] && stq0.size() > 0) begin
          s = stq0.pop_front();
          ra[0] = s.a; rb[0] = s.b; rop[0] = s.op; rv[0] = 1'b1;
        end
        if (!rv[1] && stq1.size() > 0) begin
          s = stq1.pop_front();
          ra[1] = s.a; rb[1] = s.b; rop[1] = s.op; rv[1] = 1'b1;
        end
      end
      for (int p = 0; p < 2; p++) rr[p] = rnd_rdy ? ($urandom_range(0, 9) < 7) : rdy_force[p];
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (stq0.size() == 0 && stq1.size() == 0 && !rv[0] && !rv[1] && m_phase == 0 && sb.size() == 0) return;
      cyc();
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1100, 4'b1000, 4'b0111, 4'b1111};
    reset = 1'b0;
    repeat (3) cyc();
    reset = 1'b1;

    // Single ADD with carry-out; a second request shows readiness three cycles after acceptance.
    stq0.push_back('{op: 4'b0010, a: '1, b: 64'd1});
    stq0.push_back('{op: 4'b0010, a: 64'd2, b: 64'd3});
    wait_idle(50);

    // Contention straight after reset: grants alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      stq0.push_back('{op: 4'b0000, a: 64'hF0, b: 64'h3C});
      stq1.push_back('{op: 4'b0110, a: 64'd5, b: 64'd7});
    end
    wait_idle(50);

    // Backpressure on requester 1 while requester 0 waits.
    rdy_force[1] = 1'b0;
    stq1.push_back('{op: 4'b0001, a: 64'hA, b: 64'h5});
    cyc();
    stq0.push_back('{op: 4'b0010, a: 64'd1, b: 64'd1});
    repeat (7) cyc();
    rdy_force[1] = 1'b1;
    wait_idle(50);

    // Illegal opcode, then shift and NOR.
    stq0.push_back('{op: 4'b0111, a: 64'h1234, b: 64'h5678});
    stq0.push_back('{op: 4'b1000, a: 64'd3, b: 64'd4});
    stq1.push_back('{op: 4'b1100, a: 64'd0, b: 64'd0});
    stq0.push_back('{op: 4'b1000, a: '1, b: 64'd1});
    wait_idle(60);

    // Reset while an operation is in ISSUE; it must vanish, and priority returns to RR_INIT.
    stq1.push_back('{op: 4'b0010, a: 64'd9, b: 64'd9});
    for (int i = 0; i < 20 && m_phase != 1; i++) cyc();
    chk("reached_issue", m_phase, 1);
    reset = 1'b0;
    repeat (2) cyc();
    reset = 1'b1;
    stq0.push_back('{op: 4'b0001, a: 64'h100, b: 64'h1});
    stq1.push_back('{op: 4'b0110, a: 64'd0, b: 64'd1});
    wait_idle(50);

    // Randomized traffic with random response backpressure.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      stq0.push_back('{op: ops[$urandom_range(0, 7)], a: rnd_val(), b: rnd_val()});
      stq1.push_back('{op: ops[$urandom_range(0, 7)], a: rnd_val(), b: rnd_val()});
    end
    wait_idle(20000);
    rnd_rdy = 1'b0;
    repeat (2) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational 64-bit ALU between two requesters, e.g. port 0 = execute stage, port 1 = address/branch-target unit.
- Arbitrates with round-robin priority and latches the granted operands into registers that drive the ALU.
- Captures the 65-bit ALU result into a response register and holds it until the owning requester accepts it.
- Sits between the pipeline's requesters and the ALU instance.

Parameters:
- WIDTH, 64, operand width; the result is WIDTH+1 bits.
- RR_INIT, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  arbiter accepts requester 0 this cycle
- req0_a  in  WIDTH  operand a
- req0_b  in  WIDTH  operand b
- req0_op  in  4  ALUOp code
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as above, for requester 1
- alu_a  out  WIDTH  registered operand a to the ALU
- alu_b  out  WIDTH  registered operand b to the ALU
- alu_op  out  4  registered op to the ALU
- alu_result  in  WIDTH+1  combinational result from the ALU
- rsp0_valid  out  1  response for requester 0 is available
- rsp1_valid  out  1  response for requester 1 is available
- rsp0_ready  in  1  requester 0 accepts its response
- rsp1_ready  in  1  requester 1 accepts its response
- rsp_result  out  WIDTH+1  captured result, shared by both response ports
- rsp_err  out  1  operation had an unsupported opcode
- busy  out  1  state is not IDLE

Behaviour:
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 1000 shift-left (a·2^b). All other codes are illegal.
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE, ready generation:
  - reqX_ready is combinational: high only in IDLE, and only for the granted requester.
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester named by priority pointer `prio` is granted.
  - At most one ready is high in any cycle. A ready may rise combinationally in response to valid.
- IDLE, handshake: when reqX_valid and reqX_ready are both high at a clock edge:
  - latch a, b, op and owner = X;
  - set `prio` to the other requester;
  - move to ISSUE.
  - `prio` changes only on a grant. It is never updated in ISSUE or RESP.
- ISSUE (exactly one cycle):
  - alu_a, alu_b, alu_op come straight from the latched registers and are stable for the whole cycle.
  - For an illegal op, alu_op is driven 0000.
  - At the end of the cycle: rsp_result <= alu_result, or 0 for an illegal op; rsp_err <= illegal; move to RESP.
- RESP:
  - rsp<owner>_valid = 1; the other rsp valid = 0.
  - rsp_result and rsp_err are held stable.
  - When rsp<owner>_ready = 1 at a clock edge: move to IDLE and drop valid in the next cycle.
  - rsp_ready from the non-owner is ignored.
- Latency and throughput:
  - Request accepted at edge N → rsp valid from cycle N+2.
  - Accepted with rsp_ready already high → ready again at N+3.
  - Minimum of 3 cycles per operation.
- While not IDLE, both req_ready outputs are 0. Valids may stay asserted; requests are not lost, they are served later.
- Result width: the ALU's 65-bit result is passed through unmodified, including the carry/shift bit 64. No truncation.
- Reset (any time, including mid-operation):
  - state = IDLE, prio = RR_INIT;
  - alu_a, alu_b, alu_op, rsp_result, rsp_err = 0;
  - both rsp valids = 0, busy = 0;
  - any in-flight operation is discarded with no response.
- After reset deasserts, the first edge may accept a request.
- Operand registers load only on a grant. alu_* outputs keep their last value in IDLE and RESP.

Test Plan:
- Single request: req0 ADD, a=0xFFFF_FFFF_FFFF_FFFF, b=1, rsp0_ready tied high → rsp0_valid exactly at N+2, rsp_result=0x1_0000_0000_0000_0000, rsp_err=0, req0_ready high again at N+3.
- Contention: both valid every cycle after reset with RR_INIT=0; req0 AND 0xF0&0x3C, req1 SUB 5-7 → grants in order 0,1,0,1; results 0x30 and 65-bit two's-complement of -2 (0x1_FFFF_FFFF_FFFF_FFFE) on the correct rsp port.
- Backpressure: req1 OR 0xA|0x5, hold rsp1_ready=0 for 5 cycles → rsp1_valid and rsp_result=0xF stable all 5 cycles, req0_ready=0 throughout, busy=1; IDLE one cycle after ready.
- Illegal op: req0 op=0111 → alu_op=0000 during ISSUE, rsp_result=0, rsp_err=1; prio flips to 1.
- Shift and NOR: op 1000 a=3 b=4 → 0x30; op 1100 a=0 b=0 → 0x1_FFFF_FFFF_FFFF_FFFF (65-bit ~0).
- Reset mid-op: assert reset during ISSUE → no rsp valid ever appears for that op, all outputs 0, prio=RR_INIT; the next request completes normally.
